// File: rtl/ula_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ula_pkg
//  Description : Shared types for the sequential ALU (ula_seq).
//                - OP_W    : opcode width
//                - op_t    : opcode encoding (ADD..MUL)
//                - state_t : controller state encoding (IDLE, EXEC, MUL)
//  Revision    : 1.0  initial release
// ============================================================================
package ula_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_SHR = 3'd2,
        OP_SHL = 3'd3,
        OP_AND = 3'd4,
        OP_OR  = 3'd5,
        OP_XOR = 3'd6,
        OP_MUL = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MUL  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/ula_mul_seq.sv
`default_nettype none
// ============================================================================
//  Module      : ula_mul_seq
//  Description : Unsigned shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH.
//                The first partial product is folded into the load cycle,
//                so `done` rises WIDTH-1 edges after `load` and the owner
//                can register `product` on the WIDTH-th edge.
//  Ports       : clk, rst_n (async, active-low)
//                load     - capture a/b and start (ignored while busy)
//                a, b     - unsigned operands
//                busy     - iteration in progress
//                done     - product is final this cycle (combinational)
//                product  - running / final 2*WIDTH-bit product
//  Revision    : 1.0  initial release
// ============================================================================
module ula_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int               CNT_W       = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] c_LAST_ITER = CNT_W'(WIDTH - 1);

    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
        end else if (load && !r_busy) begin
            // Bit 0 of b is consumed here; the remaining WIDTH-1 bits follow.
            r_acc    <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
            r_mcand  <= {{WIDTH{1'b0}}, a} << 1;
            r_mplier <= b >> 1;
            r_cnt    <= c_LAST_ITER;
            r_busy   <= 1'b1;
        end else if (r_busy) begin
            if (r_cnt != '0) begin
                r_acc    <= r_acc + (r_mplier[0] ? r_mcand : '0);
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt - CNT_W'(1);
            end else begin
                r_busy   <= 1'b0;
            end
        end
    end

    assign busy    = r_busy;
    assign done    = r_busy && (r_cnt == '0);
    assign product = r_acc;

endmodule
`default_nettype wire

// File: rtl/ula_seq.sv
`default_nettype none
// ============================================================================
//  Module      : ula_seq
//  Description : Registered, handshaked WIDTH-bit ALU. One operation at a
//                time: start (sampled while !busy) captures sel/a/b, the
//                result registers update on completion and done pulses for
//                one cycle. Ops 0-6 take one edge; MUL takes WIDTH edges.
//  Config      : ULA_MUL_EN - build the shift-add multiplier for sel=7.
//                Without it sel=7 completes in one edge with output_s=0,
//                ovf=1 as an unsupported-op marker.
//  Ports       : clk, rst_n (async, active-low)
//                start, sel[2:0], input_a, input_b  - request side
//                busy, done, output_s, ovf, zero    - status / result
//  Revision    : 1.0  initial release
// ============================================================================
module ula_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       sel,
    input  logic [WIDTH-1:0] input_a,
    input  logic [WIDTH-1:0] input_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] output_s,
    output logic             ovf,
    output logic             zero
);

    import ula_pkg::*;

    localparam logic [1:0]     c_S_IDLE  = IDLE;
    localparam logic [1:0]     c_S_EXEC  = EXEC;
    localparam logic [1:0]     c_S_MUL   = MUL;
    localparam logic [WIDTH:0] c_WIDTH_V = (WIDTH + 1)'(WIDTH);

    logic [1:0]       r_state;
    op_t              r_sel;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_s;
    logic             r_ovf;
    logic             r_zero;

    // ------------------------------------------------------------------
    // Single-cycle datapath, fed only from the capture registers
    // ------------------------------------------------------------------
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic [2*WIDTH-1:0] w_shl_full;
    logic               w_shift_big;
    logic [WIDTH-1:0]   w_res;
    logic               w_ovf;

    assign w_sum       = {1'b0, r_a} + {1'b0, r_b};
    assign w_diff      = {1'b0, r_a} - {1'b0, r_b};   // MSB set <=> a < b
    assign w_shl_full  = {{WIDTH{1'b0}}, r_a} << r_b;
    assign w_shift_big = ({1'b0, r_b} >= c_WIDTH_V);

    always_comb begin
        w_res = '0;
        w_ovf = 1'b0;
        case (r_sel)
            OP_ADD: begin
                w_res = w_sum[WIDTH-1:0];
                w_ovf = w_sum[WIDTH];
            end
            OP_SUB: begin
                w_res = w_diff[WIDTH-1:0];
                w_ovf = w_diff[WIDTH];
            end
            OP_SHR: begin
                w_res = w_shift_big ? '0 : (r_a >> r_b);
            end
            OP_SHL: begin
                // Any set bit of a is lost when the whole word shifts out.
                if (w_shift_big) begin
                    w_res = '0;
                    w_ovf = |r_a;
                end else begin
                    w_res = w_shl_full[WIDTH-1:0];
                    w_ovf = |w_shl_full[2*WIDTH-1:WIDTH];
                end
            end
            OP_AND: w_res = r_a & r_b;
            OP_OR:  w_res = r_a | r_b;
            OP_XOR: w_res = r_a ^ r_b;
            default: begin
                // MUL reaching the one-cycle path: unsupported-op marker.
                w_res = '0;
                w_ovf = 1'b1;
            end
        endcase
    end

`ifdef ULA_MUL_EN
    // ------------------------------------------------------------------
    // Multiplier: loaded straight from the request inputs on the same
    // edge that captures them, so it finishes on the WIDTH-th edge.
    // ------------------------------------------------------------------
    logic               w_mul_load;
    logic               w_mul_busy;
    logic               w_mul_done;
    logic [2*WIDTH-1:0] w_prod;

    assign w_mul_load = (r_state == c_S_IDLE) && start && (sel == OP_MUL);

    ula_mul_seq #(
        .WIDTH   (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (w_mul_load),
        .a       (input_a),
        .b       (input_b),
        .busy    (w_mul_busy),
        .done    (w_mul_done),
        .product (w_prod)
    );
`endif

    // ------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_S_IDLE;
            r_sel   <= OP_ADD;
            r_a     <= '0;
            r_b     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_s     <= '0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b1;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    if (start) begin
                        r_sel  <= op_t'(sel);
                        r_a    <= input_a;
                        r_b    <= input_b;
                        r_busy <= 1'b1;
`ifdef ULA_MUL_EN
                        r_state <= (sel == OP_MUL) ? c_S_MUL : c_S_EXEC;
`else
                        r_state <= c_S_EXEC;
`endif
                    end
                end
                c_S_EXEC: begin
                    r_s     <= w_res;
                    r_ovf   <= w_ovf;
                    r_zero  <= (w_res == '0);
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= c_S_IDLE;
                end
                c_S_MUL: begin
`ifdef ULA_MUL_EN
                    if (w_mul_done) begin
                        r_s     <= w_prod[WIDTH-1:0];
                        r_ovf   <= |w_prod[2*WIDTH-1:WIDTH];
                        r_zero  <= (w_prod[WIDTH-1:0] == '0);
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= c_S_IDLE;
                    end else if (!w_mul_busy) begin
                        // Multiplier idle without finishing: recover quietly.
                        r_busy  <= 1'b0;
                        r_state <= c_S_IDLE;
                    end
`else
                    r_busy  <= 1'b0;
                    r_state <= c_S_IDLE;
`endif
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign output_s = r_s;
    assign ovf      = r_ovf;
    assign zero     = r_zero;

endmodule
`default_nettype wire
